// File: rtl/rv32_pkg.sv
// Shared definitions for the nano_rv32i register file family:
// default data width, the hard-wired zero index and the clear-sequencer states.
package rv32_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_ZERO = 0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits with set/clear priority and one lookup per read port.
// A same-cycle issue to the index being retired wins, since it belongs to a younger instruction.
module regfile_scoreboard
  import rv32_pkg::*;
#(
  parameter  int NREGS = 32,
  parameter  int NRP   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_en_i,
  input  logic [AW-1:0]     clr_idx_i,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_idx_i,
  input  logic              iss_en_i,
  input  logic [AW-1:0]     iss_idx_i,
  input  logic [NRP*AW-1:0] rs_i,
  output logic [NRP-1:0]    pend_o
);

  logic [NREGS-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_idx_i] = 1'b0;
    if (wr_en_i)  pend_d[wr_idx_i]  = 1'b0;
    if (iss_en_i && iss_idx_i != AW'(REG_ZERO)) pend_d[iss_idx_i] = 1'b1;
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  for (genvar k = 0; k < NRP; k++) begin : g_lookup
    assign pend_o[k] = pend_q[rs_i[k*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional write bypass, pending-write scoreboard
// and a soft clear sequencer that zeroes x1..x(NREGS-1) one register per cycle.
module regfile_mp
  import rv32_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = 32,
  parameter  int NRP    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  output logic                busy_o,
  input  logic [NRP*AW-1:0]   rs_i,
  output logic [NRP*XLEN-1:0] rs_data_o,
  output logic [NRP-1:0]      rs_pending_o,
  input  logic                reg_write_i,
  input  logic [AW-1:0]       rd_i,
  input  logic [XLEN-1:0]     write_data_i,
  input  logic                issue_en_i,
  input  logic [AW-1:0]       issue_rd_i
);

  clr_state_e                 state_q, state_d;
  logic [AW-1:0]              idx_q, idx_d;
  logic                       busy_q, busy_d;
  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NRP-1:0]             sb_pend;
  logic                       clearing, wr_fire;

  assign clearing = (state_q == CLEAR);
  assign wr_fire  = reg_write_i && !clearing && (rd_i != AW'(REG_ZERO));
  assign busy_o   = busy_q;

  // Clear sequencer: walks idx from 1 to NREGS-1, ignores further clear_i pulses.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: if (clear_i) begin
        state_d = CLEAR;
        idx_d   = AW'(1);
        busy_d  = 1'b1;
      end
      CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREGS-1)) begin
          state_d = IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (clearing)     regs_d[idx_q] = '0;
    else if (wr_fire) regs_d[rd_i]  = write_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      regs_q  <= regs_d;
    end
  end

  regfile_scoreboard #(.NREGS(NREGS), .NRP(NRP)) u_sb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_en_i  (clearing),
    .clr_idx_i (idx_q),
    .wr_en_i   (reg_write_i && !clearing),
    .wr_idx_i  (rd_i),
    .iss_en_i  (issue_en_i && !clearing),
    .iss_idx_i (issue_rd_i),
    .rs_i      (rs_i),
    .pend_o    (sb_pend)
  );

  // Reads are masked to zero while clearing so consumers never see half-cleared state.
  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0] rs;
    logic          kill, byp;
    assign rs   = rs_i[k*AW +: AW];
    assign kill = clearing || (rs == AW'(REG_ZERO));
    assign byp  = (BYPASS != 0) && wr_fire && (rd_i == rs);
    assign rs_data_o[k*XLEN +: XLEN] = kill ? '0 : (byp ? write_data_i : regs_q[rs]);
    assign rs_pending_o[k]           = !kill && !byp && sb_pend[k];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: bypass and non-bypass instances share stimulus,
// a third instance covers NRP=4 / NREGS=16 / XLEN=64.
module tb_regfile_mp;

  localparam int S0D0 = 0,  S0D1 = 1, S0P0 = 2, S0P1 = 3, S0B = 4;
  localparam int S1D0 = 5,  S1D1 = 6, S1P0 = 7, S1P1 = 8, S1B = 9;
  localparam int S2D  = 10, S2P  = 14, S2B = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        clear, we, iss;
  logic [4:0]  rd, iss_rd;
  logic [31:0] wd;
  logic [9:0]  rs;
  logic [63:0] d0, d1;
  logic [1:0]  p0, p1;
  logic        b0, b1;

  logic         clear2, we2, iss2;
  logic [3:0]   rd2, iss_rd2;
  logic [63:0]  wd2;
  logic [15:0]  rs2;
  logic [255:0] d2;
  logic [3:0]   p2;
  logic         b2;

  regfile_mp #(.BYPASS(1)) u0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(b0),
    .rs_i(rs), .rs_data_o(d0), .rs_pending_o(p0),
    .reg_write_i(we), .rd_i(rd), .write_data_i(wd),
    .issue_en_i(iss), .issue_rd_i(iss_rd));

  regfile_mp #(.BYPASS(0)) u1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(b1),
    .rs_i(rs), .rs_data_o(d1), .rs_pending_o(p1),
    .reg_write_i(we), .rd_i(rd), .write_data_i(wd),
    .issue_en_i(iss), .issue_rd_i(iss_rd));

  regfile_mp #(.XLEN(64), .NREGS(16), .NRP(4), .BYPASS(1)) u2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear2), .busy_o(b2),
    .rs_i(rs2), .rs_data_o(d2), .rs_pending_o(p2),
    .reg_write_i(we2), .rd_i(rd2), .write_data_i(wd2),
    .issue_en_i(iss2), .issue_rd_i(iss_rd2));

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   nchk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs(input int sel);
    case (sel)
      S0D0: return 64'(d0[31:0]);
      S0D1: return 64'(d0[63:32]);
      S0P0: return 64'(p0[0]);
      S0P1: return 64'(p0[1]);
      S0B:  return 64'(b0);
      S1D0: return 64'(d1[31:0]);
      S1D1: return 64'(d1[63:32]);
      S1P0: return 64'(p1[0]);
      S1P1: return 64'(p1[1]);
      S1B:  return 64'(b1);
      S2B:  return 64'(b2);
      default: begin
        if (sel >= S2D && sel < S2D + 4) return d2[(sel-S2D)*64 +: 64];
        if (sel >= S2P && sel < S2P + 4) return 64'(p2[sel-S2P]);
        return 'x;
      end
    endcase
  endfunction

  task automatic exp_push(input string tag, input int sel, input logic [63:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    q.push_back(e);
  endtask

  task automatic drain;
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk); drain();
  endtask

  function automatic logic [63:0] val2(input int i);
    return 64'hA5A5_0000_0000_0000 | (64'(i) * 64'h0001_0001_0001_0001);
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    bit done;
    rst = 1'b1; clear = 0; we = 0; iss = 0; rd = 0; iss_rd = 0; wd = 0; rs = {5'd2, 5'd1};
    clear2 = 0; we2 = 0; iss2 = 0; rd2 = 0; iss_rd2 = 0; wd2 = 0; rs2 = 0;
    repeat (2) tick();
    exp_push("rst_busy", S0B, 0);
    exp_push("rst_d0", S0D0, 0);
    exp_push("rst_d1", S0D1, 0);
    exp_push("rst_p0", S0P0, 0);
    exp_push("rst_busy2", S2B, 0);
    smp(); tick();
    rst = 1'b0;

    // Basic writes and reads
    we = 1; rd = 1; wd = 32'hDEADBEEF; tick();
    rd = 2; wd = 32'hCAFEBABE; tick();
    we = 0; rs = {5'd2, 5'd1};
    exp_push("rd_p0", S0D0, 32'hDEADBEEF);
    exp_push("rd_p1", S0D1, 32'hCAFEBABE);
    exp_push("rd_p0_nb", S1D0, 32'hDEADBEEF);
    exp_push("rd_p1_nb", S1D1, 32'hCAFEBABE);
    smp(); tick();
    we = 1; rd = 0; wd = 32'hFFFFFFFF; tick();
    we = 0; rs = 10'd0;
    exp_push("x0_data", S0D0, 0);
    exp_push("x0_pend", S0P0, 0);
    smp(); tick();

    // Bypass vs non-bypass on the same write
    we = 1; rd = 5; wd = 32'h12345678; rs = {5'd0, 5'd5};
    exp_push("byp_data", S0D0, 32'h12345678);
    exp_push("byp_pend", S0P0, 0);
    exp_push("nobyp_old", S1D0, 0);
    smp(); tick();
    we = 0;
    exp_push("byp_after", S0D0, 32'h12345678);
    exp_push("nobyp_after", S1D0, 32'h12345678);
    smp(); tick();

    // Scoreboard set, clear, and set-wins
    iss = 1; iss_rd = 7; tick();
    iss = 0; rs = {5'd7, 5'd0};
    exp_push("sb_set", S0P1, 1);
    exp_push("sb_set_nb", S1P1, 1);
    smp(); tick();
    we = 1; rd = 7; wd = 32'h77;
    exp_push("sb_wr_byp", S0P1, 0);
    exp_push("sb_wr_bypd", S0D1, 32'h77);
    exp_push("sb_wr_nb", S1P1, 1);
    exp_push("sb_wr_nbd", S1D1, 0);
    smp(); tick();
    we = 0;
    exp_push("sb_clr", S0P1, 0);
    exp_push("sb_clr_nb", S1P1, 0);
    exp_push("sb_clr_nbd", S1D1, 32'h77);
    smp(); tick();
    iss = 1; iss_rd = 7; we = 1; rd = 7; wd = 32'h88; tick();
    iss = 0; we = 0;
    exp_push("sb_setwins", S0P1, 1);
    exp_push("sb_setwins_nb", S1P1, 1);
    exp_push("sb_setwins_d", S0D1, 32'h88);
    smp(); tick();
    we = 1; rd = 7; wd = 0; tick();
    we = 0;

    // Fill, then soft clear
    for (int i = 1; i < 32; i++) begin
      we = 1; rd = 5'(i); wd = 32'(i); tick();
    end
    we = 0; iss = 1; iss_rd = 3; tick();
    iss = 0; rs = {5'd31, 5'd3};
    exp_push("fill_x3", S0D0, 3);
    exp_push("fill_x3p", S0P0, 1);
    exp_push("fill_x31", S0D1, 31);
    smp(); tick();
    clear = 1; tick();
    clear = 0; rs = {5'd9, 5'd3};
    cnt = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      we = (c == 5); rd = 9; wd = 32'h999;
      iss = (c == 6); iss_rd = 10;
      clear = (c == 8);
      @(negedge clk);
      if (b0) begin
        cnt++;
        exp_push("clr_d0", S0D0, 0);
        exp_push("clr_p0", S0P0, 0);
        exp_push("clr_d1", S0D1, 0);
        exp_push("clr_p1", S0P1, 0);
        exp_push("clr_d0_nb", S1D0, 0);
        drain();
      end else begin
        done = 1;
      end
      tick();
    end
    we = 0; iss = 0; clear = 0;
    chk("clr_len", 64'(cnt), 31);
    for (int i = 1; i < 32; i++) begin
      rs = {5'(i), 5'(i)};
      exp_push("post_clr_d", S0D0, 0);
      exp_push("post_clr_p", S0P0, 0);
      exp_push("post_clr_nb", S1D0, 0);
      smp(); tick();
    end

    // Reset in the middle of a clear
    we = 1; rd = 31; wd = 32'h31313131; tick();
    we = 0; iss = 1; iss_rd = 20; tick();
    iss = 0; clear = 1; tick();
    clear = 0;
    repeat (10) tick();
    #2;
    exp_push("midclr_busy", S0B, 1);
    drain();
    rst = 1'b1; #1;
    exp_push("midrst_busy", S0B, 0);
    exp_push("midrst_busy_nb", S1B, 0);
    drain();
    rs = {5'd20, 5'd31}; #1;
    exp_push("midrst_x31", S0D0, 0);
    exp_push("midrst_x31_nb", S1D0, 0);
    exp_push("midrst_p20", S0P1, 0);
    drain();
    tick();
    rst = 1'b0;
    we = 1; rd = 4; wd = 32'hA5A5A5A5; tick();
    we = 0; rs = {5'd0, 5'd4};
    exp_push("post_rst_x4", S0D0, 32'hA5A5A5A5);
    exp_push("post_rst_x4_nb", S1D0, 32'hA5A5A5A5);
    smp(); tick();

    // Wide instance: four ports, 16 regs, 64-bit data
    for (int i = 1; i <= 4; i++) begin
      we2 = 1; rd2 = 4'(i); wd2 = val2(i); tick();
    end
    we2 = 0; rs2 = {4'd2, 4'd4, 4'd1, 4'd3};
    exp_push("w_p0", S2D + 0, val2(3));
    exp_push("w_p1", S2D + 1, val2(1));
    exp_push("w_p2", S2D + 2, val2(4));
    exp_push("w_p3", S2D + 3, val2(2));
    smp(); tick();
    iss2 = 1; iss_rd2 = 15; tick();
    iss2 = 0; rs2 = {4'd15, 4'd4, 4'd1, 4'd3};
    exp_push("w_pend15", S2P + 3, 1);
    exp_push("w_pend3", S2P + 0, 0);
    smp(); tick();
    clear2 = 1; tick();
    clear2 = 0;
    cnt = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (b2) cnt++;
      else    done = 1;
      tick();
    end
    chk("w_clr_len", 64'(cnt), 15);
    exp_push("w_post_p2", S2D + 2, 0);
    exp_push("w_post_pend", S2P + 3, 0);
    smp(); tick();

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, two-read register file for nano_rv32i.
- Provides NRP combinational read ports, one write port, and a per-register pending-write scoreboard for hazard detection.
- Adds an optional write-to-read bypass and a multi-cycle clear sequencer for soft re-initialisation without asserting reset.
- Sits in ID stage: decode drives read indices and issue marks; WB stage drives the write port.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, >= 4; register 0 is hard-wired zero.
- NRP, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = read returns stored value.
- AW, $clog2(NREGS), index width (derived, not overridable).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- clear_i  in  1  one-cycle pulse; starts clear sequence.
- busy_o  out  1  high while clear sequence runs.
- rs_i  in  NRP*AW  packed read indices; port k = bits [k*AW +: AW].
- rs_data_o  out  NRP*XLEN  packed read data; port k = bits [k*XLEN +: XLEN].
- rs_pending_o  out  NRP  port k's register has an outstanding write.
- reg_write_i  in  1  write enable.
- rd_i  in  AW  write index.
- write_data_i  in  XLEN  write data.
- issue_en_i  in  1  mark issue_rd_i pending.
- issue_rd_i  in  AW  destination of newly issued instruction.

Behaviour:
- Reset (async, rst_i=1):
  - All registers = 0; all pending bits = 0.
  - FSM = IDLE; busy_o = 0.
  - Reset release is synchronous to next edge (no glitch dependence).
- Reads:
  - Combinational, zero latency.
  - Index 0 always returns 0 and pending 0.
- Bypass (BYPASS=1):
  - When reg_write_i=1, rd_i!=0 and rd_i==rs_i[k], rs_data_o[k] = write_data_i and rs_pending_o[k] = 0 in the same cycle.
  - With BYPASS=0, the stored value appears the cycle after the write edge.
- Writes:
  - On rising edge when reg_write_i=1 and rd_i!=0, reg[rd_i] <= write_data_i.
  - Writes to 0 are discarded.
- Scoreboard:
  - Per edge: pending[rd_i] clears if reg_write_i; pending[issue_rd_i] sets if issue_en_i and issue_rd_i!=0.
  - Same index both set and cleared in one cycle: set wins (younger instruction issued).
  - Different indices: both take effect.
- FSM states:
  - IDLE: clear_i=1 moves to CLEAR with idx=1; busy_o=1 from the next cycle.
  - CLEAR: each cycle writes reg[idx] <= 0 and pending[idx] <= 0, then idx++.
  - Exit: at idx==NREGS-1, returns to IDLE the following cycle. Duration NREGS-1 cycles (31 by default).
  - Back-to-back clear: clear_i while in CLEAR is ignored (no restart).
- During CLEAR:
  - reg_write_i and issue_en_i are ignored.
  - All rs_data_o = 0 and rs_pending_o = 0, regardless of BYPASS.
- rst_i asserted mid-CLEAR aborts immediately to IDLE with all state zeroed.
- busy_o is registered.
- Width: idx is AW bits. Terminal compare is against NREGS-1, so no wrap occurs.

Decomposition:
- Shared package rv32_pkg: XLEN default, REG_ZERO index constant, clear-FSM state enum {IDLE, CLEAR}.
- One sub-module: regfile_scoreboard (pending bit vector, set/clear/priority logic, NRP lookup).
- Storage, bypass and FSM stay in the top level.

Test Plan:
- Reset, write, read:
  - Stimulus: rst_i=1 for 2 cycles, release; write x1=DEADBEEF, x2=CAFEBABE; read rs_i={2,1}.
  - Required: port0=DEADBEEF, port1=CAFEBABE; read x0 returns 0 after writing x0=FFFFFFFF.
- Bypass:
  - Stimulus: BYPASS=1, reg_write_i=1, rd_i=5, write_data_i=12345678, rs_i[0]=5 in the same cycle.
  - Required: rs_data_o[0]=12345678 that cycle. Rerun with BYPASS=0: old value 0 that cycle, 12345678 the next.
- Scoreboard:
  - Stimulus: issue x7; next cycle rs_i[1]=7; then write x7.
  - Required: rs_pending_o[1]=1 after issue; 0 after write.
  - Stimulus: issue x7 and write x7 in the same cycle. Required: pending stays 1.
- Clear:
  - Stimulus: fill x1..x31 with index value, issue x3, pulse clear_i.
  - Required: busy_o high exactly 31 cycles; reads = 0 throughout; afterwards all regs 0 and pending 0.
  - Stimulus: write x9 during clear. Required: discarded.
- Reset mid-clear:
  - Stimulus: assert rst_i asynchronously (off-edge) at clear cycle 10.
  - Required: busy_o = 0 immediately; all regs 0.
  - Stimulus: after release, write x4=A5A5A5A5. Required: reads back A5A5A5A5.
- Parameter sweep:
  - Stimulus: NRP=4, NREGS=16, XLEN=64; four ports read distinct registers.
  - Required: each port returns its own data. Clear duration is 15 cycles.
